// File: rtl/counter_updown_mod_if.sv
// Control/status bundle for counter_updown_mod: the owner drives the controls,
// the counter returns its registered count, terminal pulse and one-shot flag.
interface counter_updown_mod_if #(
  parameter int DW = 8,
  parameter int PW = 4
);
  logic          ena;
  logic          dir;
  logic          load;
  logic [DW-1:0] load_val;
  logic [DW-1:0] limit;
  logic [1:0]    mode;
  logic [PW-1:0] prescale;
  logic [DW-1:0] result;
  logic          tc;
  logic          done;

  modport master (
    output ena, dir, load, load_val, limit, mode, prescale,
    input  result, tc, done
  );

  modport slave (
    input  ena, dir, load, load_val, limit, mode, prescale,
    output result, tc, done
  );
endinterface

// File: rtl/counter_updown_mod.sv
// Up/down counter with programmable limit, parallel load, wrap/saturate/one-shot
// modes, an enable prescaler and a registered terminal-count pulse.
module counter_updown_mod #(
  parameter int DW   = 8,
  parameter int INIT = 7,
  parameter int PW   = 4
) (
  input  logic clk,
  input  logic reset,
  counter_updown_mod_if.slave bus
);

  typedef enum logic [1:0] {
    M_WRAP  = 2'b00,
    M_SAT   = 2'b01,
    M_ONE   = 2'b10,
    M_WRAP3 = 2'b11
  } mode_e;

  mode_e         mode_v;
  logic [DW-1:0] res_q, res_d, stepv, term;
  logic [PW-1:0] pc_q, pc_d;
  logic          tc_q, tc_d, done_q, done_d;
  logic          tick, wrap_m;

  assign mode_v = mode_e'(bus.mode);

  always_comb begin
    tick   = bus.ena & (pc_q == bus.prescale);
    term   = bus.dir ? bus.limit : '0;
    wrap_m = (mode_v == M_WRAP) || (mode_v == M_WRAP3);
    // ">= limit" also catches counts left above a freshly lowered limit
    if (bus.dir)
      stepv = (res_q >= bus.limit) ? (wrap_m ? '0 : bus.limit) : res_q + DW'(1);
    else
      stepv = (res_q == '0) ? (wrap_m ? bus.limit : '0) : res_q - DW'(1);

    res_d  = res_q;
    pc_d   = pc_q;
    tc_d   = 1'b0;
    done_d = done_q;
    if (bus.load) begin
      res_d  = bus.load_val;
      pc_d   = '0;
      done_d = 1'b0;
    end else if (bus.ena) begin
      pc_d = tick ? '0 : pc_q + PW'(1);
      if (tick && !done_q) begin
        res_d = stepv;
        tc_d  = (stepv != res_q) && (stepv == term);
        if (mode_v == M_ONE && stepv == term) done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      res_q  <= DW'(INIT);
      pc_q   <= '0;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      pc_q   <= pc_d;
      tc_q   <= tc_d;
      done_q <= done_d;
    end
  end

  assign bus.result = res_q;
  assign bus.tc     = tc_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: an 8-bit and a 4-bit instance share stimulus and
// are compared each cycle against an integer reference model plus directed values.
module tb_counter_updown_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       ena = 1'b0, dir = 1'b0, load = 1'b0;
  logic [7:0] lv = '0, lim = '0;
  logic [1:0] mode = '0;
  logic [3:0] ps = '0;

  int total = 0;
  int bad   = 0;

  counter_updown_mod_if #(.DW(8), .PW(4)) b8();
  counter_updown_mod_if #(.DW(4), .PW(4)) b4();

  assign b8.ena = ena;  assign b8.dir = dir;  assign b8.load = load;
  assign b8.load_val = lv;  assign b8.limit = lim;
  assign b8.mode = mode;  assign b8.prescale = ps;
  assign b4.ena = ena;  assign b4.dir = dir;  assign b4.load = load;
  assign b4.load_val = lv[3:0];  assign b4.limit = lim[3:0];
  assign b4.mode = mode;  assign b4.prescale = ps;

  counter_updown_mod #(.DW(8), .INIT(7), .PW(4)) dut8 (
    .clk(clk), .reset(rst_n), .bus(b8.slave));
  counter_updown_mod #(.DW(4), .INIT(15), .PW(4)) dut4 (
    .clk(clk), .reset(rst_n), .bus(b4.slave));

  typedef struct {
    int res;
    int pc;
    bit tc;
    bit done;
  } mst_t;

  mst_t m8, m4;

  // Reference: plain integer arithmetic on the counting rules, inputs read as sampled.
  function automatic mst_t nxt(mst_t s, int dw, int init);
    int  msk, l, t, n;
    bit  wrapm, tk;
    msk = (1 << dw) - 1;
    l   = int'(lim) & msk;
    s.tc = 1'b0;
    if (!rst_n) begin
      s.res = init; s.pc = 0; s.done = 1'b0;
    end else if (load) begin
      s.res = int'(lv) & msk; s.pc = 0; s.done = 1'b0;
    end else if (ena) begin
      tk   = (s.pc == int'(ps));
      s.pc = tk ? 0 : (s.pc + 1) % 16;
      if (tk && !s.done) begin
        wrapm = (mode == 2'd0) || (mode == 2'd3);
        t = dir ? l : 0;
        if (dir) n = (s.res >= l) ? (wrapm ? 0 : l) : s.res + 1;
        else     n = (s.res == 0) ? (wrapm ? l : 0) : s.res - 1;
        s.tc = (n != s.res) && (n == t);
        if (mode == 2'd2 && n == t) s.done = 1'b1;
        s.res = n;
      end
    end
    return s;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(posedge clk);
      m8 = nxt(m8, 8, 7);
      m4 = nxt(m4, 4, 15);
      #1;
      chk("m8.result", 32'(b8.result), 32'(m8.res));
      chk("m8.tc",     32'(b8.tc),     32'(m8.tc));
      chk("m8.done",   32'(b8.done),   32'(m8.done));
      chk("m4.result", 32'(b4.result), 32'(m4.res));
      chk("m4.tc",     32'(b4.tc),     32'(m4.tc));
      chk("m4.done",   32'(b4.done),   32'(m4.done));
    end
  endtask

  initial begin
    m8 = '{res: 0, pc: 0, tc: 1'b0, done: 1'b0};
    m4 = m8;

    // reset dominates load and enable
    rst_n = 1'b0; ena = 1'b1; load = 1'b1; lv = 8'd55;
    run(2);
    chk("rst.result", 32'(b8.result), 32'd7);
    chk("rst.tc", 32'(b8.tc), 32'd0);
    chk("rst.done", 32'(b8.done), 32'd0);
    chk("rst.result4", 32'(b4.result), 32'd15);

    // wrap down through zero
    rst_n = 1'b1; load = 1'b0; dir = 1'b0; mode = 2'd0; lim = 8'd7; ps = 4'd0;
    for (int i = 6; i >= 0; i--) begin
      run(1);
      chk("wrapdn.result", 32'(b8.result), 32'(i));
      chk("wrapdn.tc", 32'(b8.tc), (i == 0) ? 32'd1 : 32'd0);
    end
    run(1);
    chk("wrapdn.back", 32'(b8.result), 32'd7);
    chk("wrapdn.tc0", 32'(b8.tc), 32'd0);

    // prescale 2 with an enable gap mid-interval
    lv = 8'd0; lim = 8'd5; ps = 4'd2; dir = 1'b1; load = 1'b1;
    run(1); load = 1'b0;
    run(2); chk("ps.hold", 32'(b8.result), 32'd0);
    run(1); chk("ps.tick1", 32'(b8.result), 32'd1);
    run(1);
    ena = 1'b0; run(4); chk("ps.frozen", 32'(b8.result), 32'd1);
    ena = 1'b1; run(1); chk("ps.remain", 32'(b8.result), 32'd1);
    run(1); chk("ps.tick2", 32'(b8.result), 32'd2);

    // saturate up then down
    mode = 2'd1; lim = 8'd4; lv = 8'd2; ps = 4'd0; load = 1'b1;
    run(1); load = 1'b0;
    run(1); chk("sat.3", 32'(b8.result), 32'd3);
    run(1); chk("sat.4", 32'(b8.result), 32'd4); chk("sat.tc", 32'(b8.tc), 32'd1);
    run(2); chk("sat.hold", 32'(b8.result), 32'd4); chk("sat.notc", 32'(b8.tc), 32'd0);
    dir = 1'b0;
    run(4); chk("satdn.0", 32'(b8.result), 32'd0); chk("satdn.tc", 32'(b8.tc), 32'd1);
    run(1); chk("satdn.hold", 32'(b8.result), 32'd0); chk("satdn.notc", 32'(b8.tc), 32'd0);

    // one-shot, then reload clears done
    mode = 2'd2; lv = 8'd3; load = 1'b1;
    run(1); load = 1'b0;
    run(3); chk("os.0", 32'(b8.result), 32'd0);
    chk("os.done", 32'(b8.done), 32'd1); chk("os.tc", 32'(b8.tc), 32'd1);
    run(2); chk("os.after", 32'(b8.result), 32'd0); chk("os.notc", 32'(b8.tc), 32'd0);
    lv = 8'd9; load = 1'b1;
    run(1); load = 1'b0; chk("os.clr", 32'(b8.done), 32'd0);
    run(2); chk("os.resume", 32'(b8.result), 32'd7);

    // load beats step; out-of-range up wraps to zero; reset mid-count
    mode = 2'd0; lv = 8'd200; lim = 8'd10; load = 1'b1;
    run(1); chk("pri.load", 32'(b8.result), 32'd200);
    load = 1'b0; dir = 1'b1;
    run(1); chk("oor.wrap", 32'(b8.result), 32'd0); chk("oor.tc", 32'(b8.tc), 32'd0);
    run(2);
    rst_n = 1'b0; run(1); chk("midrst", 32'(b8.result), 32'd7);
    rst_n = 1'b1;

    // limit 0 in wrap mode
    lim = 8'd0; dir = 1'b0; lv = 8'd2; load = 1'b1;
    run(1); load = 1'b0;
    run(2); chk("lim0.tc", 32'(b8.tc), 32'd1);
    run(3); chk("lim0.hold", 32'(b8.result), 32'd0); chk("lim0.notc", 32'(b8.tc), 32'd0);
    dir = 1'b1; run(2); chk("lim0.up", 32'(b8.result), 32'd0);

    // 4-bit full range wrap
    lim = 8'd15; lv = 8'd14; load = 1'b1;
    run(1); load = 1'b0;
    run(1); chk("w4.15", 32'(b4.result), 32'd15); chk("w4.tc", 32'(b4.tc), 32'd1);
    run(1); chk("w4.0", 32'(b4.result), 32'd0);
    rst_n = 1'b0; run(1); rst_n = 1'b1;
    run(1); chk("w4.init", 32'(b4.result), 32'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom % 150) != 0;
      load  = ($urandom % 20) == 0;
      ena   = ($urandom % 6) != 0;
      if ($urandom % 15 == 0) dir = 1'($urandom);
      if ($urandom % 25 == 0) mode = 2'($urandom);
      if ($urandom % 40 == 0) lim = 8'($urandom % 12);
      lv = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom % 14);
      if ($urandom % 30 == 0) ps = ($urandom % 5 == 0) ? 4'($urandom) : 4'($urandom % 3);
      run(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
